read_stage: RTL and testbench

- Decode/register-read stage of the pipelined processor; sits directly upstream of the r1 pipeline register and drives its opcode, destination, operand_a, operand_b and bubble inputs.
- Decodes the 16-bit instruction held in the fetch register (r0) and reads the 8-entry register file, which is owned by this block and written by write-back.
- Forwards the execute-stage result and detects load-use hazards, generating bubble plus a fetch stall.

---
 rtl/read_stage.sv | 120 ++++++++++++
 tb/tb_read_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/read_stage.sv
// Decode / register-read stage: decodes the instruction in r0, reads the 8-entry
// register file with execute and write-back bypass, and raises bubble/stall on load-use.
module read_stage #(
  parameter int D_SIZE   = 32,
  parameter int CNT_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         r0_instruction,
  input  logic                r0_valid,
  input  logic [6:0]          r1_opcode,
  input  logic [2:0]          r1_destination,
  input  logic [D_SIZE-1:0]   ex_result,
  input  logic                wb_en,
  input  logic [2:0]          wb_dest,
  input  logic [D_SIZE-1:0]   wb_data,
  input  logic                r2_pc_halt,
  input  logic                r2_pc_flush,
  output logic [6:0]          opcode,
  output logic [2:0]          destination,
  output logic [D_SIZE-1:0]   operand_a,
  output logic [D_SIZE-1:0]   operand_b,
  output logic                bubble,
  output logic                r0_stall,
  output logic [CNT_SIZE-1:0] bubble_count
);

  localparam logic [6:0] OP_NOP   = 7'h00;
  localparam logic [6:0] OP_LOAD  = 7'h20;
  localparam logic [6:0] OP_STORE = 7'h21;
  localparam logic [6:0] OP_LOADC = 7'h22;
  localparam logic [6:0] OP_JMP   = 7'h30;
  localparam logic [6:0] OP_HALT  = 7'h7F;

  logic [D_SIZE-1:0] regs [8];

  logic [6:0] instr_op;
  logic [2:0] instr_dest;
  logic [2:0] src0;
  logic [2:0] src1;
  logic       is_alu;
  logic       is_defined;
  logic       reads_a;
  logic       reads_b;
  logic       ex_fwd_ok;
  logic       hazard;
  logic       active;
  logic [D_SIZE-1:0] val_a;
  logic [D_SIZE-1:0] val_b;

  assign instr_op   = r0_instruction[15:9];
  assign instr_dest = r0_instruction[8:6];
  assign src0       = r0_instruction[5:3];
  assign src1       = r0_instruction[2:0];

  assign is_alu     = (instr_op >= 7'h01) && (instr_op <= 7'h1F);
  assign is_defined = is_alu || (instr_op == OP_LOAD) || (instr_op == OP_STORE) ||
                      (instr_op == OP_LOADC) || (instr_op == OP_JMP) || (instr_op == OP_HALT);
  assign reads_a    = is_alu || (instr_op == OP_LOAD) || (instr_op == OP_STORE) || (instr_op == OP_JMP);
  assign reads_b    = is_alu || (instr_op == OP_STORE);

  // Only results computed in execute (ALU, LOADC) can be forwarded; a LOAD's data is not ready yet.
  assign ex_fwd_ok  = ((r1_opcode >= 7'h01) && (r1_opcode <= 7'h1F)) || (r1_opcode == OP_LOADC);

  // Younger execute result beats write-back, which beats the stored register value.
  function automatic logic [D_SIZE-1:0] read_src(input logic [2:0] s, input logic [D_SIZE-1:0] rf_val,
                                                 input logic fwd_ok, input logic [2:0] r1_d,
                                                 input logic [D_SIZE-1:0] ex_v, input logic wen,
                                                 input logic [2:0] wd, input logic [D_SIZE-1:0] wv);
    if (fwd_ok && (r1_d == s)) return ex_v;
    if (wen && (wd == s))      return wv;
    return rf_val;
  endfunction

  assign val_a = read_src(src0, regs[src0], ex_fwd_ok, r1_destination, ex_result, wb_en, wb_dest, wb_data);
  assign val_b = read_src(src1, regs[src1], ex_fwd_ok, r1_destination, ex_result, wb_en, wb_dest, wb_data);

  assign hazard = (r1_opcode == OP_LOAD) &&
                  ((reads_a && (r1_destination == src0)) || (reads_b && (r1_destination == src1)));

  // Valid qualification: r0_valid marks a real instruction; nothing is emitted during reset.
  assign active = r0_valid && !rst;

  always_comb begin
    opcode      = OP_NOP;
    destination = 3'd0;
    operand_a   = '0;
    operand_b   = '0;
    if (active && is_defined) begin
      opcode      = instr_op;
      destination = instr_dest;
      if (instr_op == OP_LOADC) begin
        operand_b = D_SIZE'(r0_instruction[5:0]);
      end else begin
        if (reads_a) operand_a = val_a;
        if (reads_b) operand_b = val_b;
      end
    end
  end

  assign bubble   = active && !r2_pc_flush && hazard;
  assign r0_stall = bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_dest] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (bubble && !r2_pc_halt && (bubble_count != {CNT_SIZE{1'b1}})) begin
      bubble_count <= bubble_count + CNT_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_read_stage.sv
// Directed bench for read_stage: decode, bypass priority, load-use hazard,
// qualification, bubble counter saturation and reset.
module tb_read_stage;

  logic        clk;
  logic        rst;
  logic [15:0] r0_instruction;
  logic        r0_valid;
  logic [6:0]  r1_opcode;
  logic [2:0]  r1_destination;
  logic [31:0] ex_result;
  logic        wb_en;
  logic [2:0]  wb_dest;
  logic [31:0] wb_data;
  logic        r2_pc_halt;
  logic        r2_pc_flush;
  logic [6:0]  opcode;
  logic [2:0]  destination;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        bubble;
  logic        r0_stall;
  logic [15:0] bubble_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_cnt;

  read_stage dut (
    .clk(clk), .rst(rst), .r0_instruction(r0_instruction), .r0_valid(r0_valid),
    .r1_opcode(r1_opcode), .r1_destination(r1_destination), .ex_result(ex_result),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .r2_pc_halt(r2_pc_halt), .r2_pc_flush(r2_pc_flush),
    .opcode(opcode), .destination(destination), .operand_a(operand_a), .operand_b(operand_b),
    .bubble(bubble), .r0_stall(r0_stall), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] d,
                                     input logic [2:0] s0, input logic [2:0] s1);
    return {op, d, s0, s1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and move 1ns past it; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; r0_instruction = mk(7'h01, 3'd1, 3'd3, 3'd5); r0_valid = 1'b1;
    r1_opcode = 7'h00; r1_destination = 3'd0; ex_result = 32'h0;
    wb_en = 1'b1; wb_dest = 3'd1; wb_data = 32'h77;
    r2_pc_halt = 1'b0; r2_pc_flush = 1'b0;
    exp_cnt = 16'd0;
    tick(); tick();
    #1;
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_dest", 32'(destination), 32'h0);
    check("rst_bubble", 32'(bubble), 32'h0);
    check("rst_stall", 32'(r0_stall), 32'h0);
    check("rst_count", 32'(bubble_count), 32'h0);

    // Release reset; wb write during reset must have been ignored.
    rst = 1'b0; wb_en = 1'b0;
    r0_instruction = mk(7'h01, 3'd2, 3'd1, 3'd5);
    #1;
    check("rst_wb_ignored", operand_a, 32'h0);

    tick();
    r0_instruction = mk(7'h01, 3'd1, 3'd3, 3'd5);
    #1;
    check("alu_opcode", 32'(opcode), 32'h01);
    check("alu_dest", 32'(destination), 32'h1);
    check("alu_a_zero", operand_a, 32'h0);
    check("alu_b_zero", operand_b, 32'h0);
    check("count_after_rst", 32'(bubble_count), 32'h0);

    // Write-back bypass in the same cycle, then regfile read next cycle.
    tick();
    wb_en = 1'b1; wb_dest = 3'd2; wb_data = 32'hDEADBEEF;
    r0_instruction = mk(7'h01, 3'd7, 3'd2, 3'd0);
    #1;
    check("wb_bypass_a", operand_a, 32'hDEADBEEF);
    tick();
    wb_en = 1'b0;
    #1;
    check("rf_read_a", operand_a, 32'hDEADBEEF);

    // Execute forward beats write-back to the same register.
    tick();
    r1_opcode = 7'h01; r1_destination = 3'd4; ex_result = 32'h55;
    wb_en = 1'b1; wb_dest = 3'd4; wb_data = 32'h11;
    r0_instruction = mk(7'h02, 3'd3, 3'd2, 3'd4);
    #1;
    check("ex_over_wb_b", operand_b, 32'h55);
    check("rf_a_same_cycle", operand_a, 32'hDEADBEEF);
    tick();
    r1_opcode = 7'h00; wb_en = 1'b0;
    #1;
    check("rf_read_b", operand_b, 32'h11);
    r1_opcode = 7'h22; r1_destination = 3'd2; ex_result = 32'h0ABC;
    #1;
    check("loadc_fwd_a", operand_a, 32'h0ABC);

    // Load-use hazard on src0.
    tick();
    r1_opcode = 7'h20; r1_destination = 3'd6;
    r0_instruction = mk(7'h03, 3'd1, 3'd6, 3'd0);
    #1;
    check("haz_bubble", 32'(bubble), 32'h1);
    check("haz_stall", 32'(r0_stall), 32'h1);
    tick(); exp_cnt = exp_cnt + 16'd1;
    check("haz_count", 32'(bubble_count), 32'(exp_cnt));

    r2_pc_flush = 1'b1;
    #1;
    check("flush_bubble", 32'(bubble), 32'h0);
    check("flush_stall", 32'(r0_stall), 32'h0);
    tick();
    check("flush_count", 32'(bubble_count), 32'(exp_cnt));
    r2_pc_flush = 1'b0;

    // Halt does not gate bubble, but the counter does not advance.
    r2_pc_halt = 1'b1;
    #1;
    check("halt_bubble", 32'(bubble), 32'h1);
    tick();
    check("halt_count", 32'(bubble_count), 32'(exp_cnt));
    r2_pc_halt = 1'b0;

    r0_valid = 1'b0;
    #1;
    check("invalid_bubble", 32'(bubble), 32'h0);
    check("invalid_opcode", 32'(opcode), 32'h0);
    r0_valid = 1'b1;

    // LOADC reads nothing: src0 field equals the load destination, no hazard.
    r0_instruction = {7'h22, 3'd5, 6'h30};
    #1;
    check("loadc_no_haz", 32'(bubble), 32'h0);
    // STORE reads src1 -> hazard; LOAD reads only src0 -> none on src1.
    r0_instruction = mk(7'h21, 3'd0, 3'd1, 3'd6);
    #1;
    check("store_src1_haz", 32'(bubble), 32'h1);
    r0_instruction = mk(7'h20, 3'd2, 3'd1, 3'd6);
    #1;
    check("load_src1_no_haz", 32'(bubble), 32'h0);

    r1_opcode = 7'h00;
    r0_instruction = {7'h22, 3'd5, 6'h2A};
    #1;
    check("loadc_a", operand_a, 32'h0);
    check("loadc_b", operand_b, 32'h2A);
    check("loadc_dest", 32'(destination), 32'h5);
    r0_instruction = mk(7'h45, 3'd3, 3'd2, 3'd4);
    #1;
    check("undef_opcode", 32'(opcode), 32'h0);
    check("undef_dest", 32'(destination), 32'h0);
    check("undef_a", operand_a, 32'h0);
    r0_instruction = mk(7'h30, 3'd1, 3'd2, 3'd4);
    #1;
    check("jmp_a", operand_a, 32'hDEADBEEF);
    check("jmp_b_unread", operand_b, 32'h0);

    // Drive the counter to saturation, then push past it.
    tick();
    r1_opcode = 7'h20; r1_destination = 3'd6;
    r0_instruction = mk(7'h03, 3'd1, 3'd6, 3'd0);
    repeat (65535 - int'(exp_cnt)) @(posedge clk);
    #1;
    check("count_full", 32'(bubble_count), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    check("count_saturate", 32'(bubble_count), 32'hFFFF);

    // Reset mid-hazard clears counter and regfile.
    rst = 1'b1;
    #1;
    check("rst_forces_bubble", 32'(bubble), 32'h0);
    tick();
    rst = 1'b0; r1_opcode = 7'h00;
    r0_instruction = mk(7'h01, 3'd1, 3'd2, 3'd4);
    #1;
    check("rst2_count", 32'(bubble_count), 32'h0);
    check("rst2_rf_a", operand_a, 32'h0);
    check("rst2_rf_b", operand_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
